// File: rtl/tt_external_memory_burst.sv
// rtl/tt_external_memory_burst.sv - burst memory model serving a DUT's time-muxed address/data bus
// Optional TTMEM_ALIGN_CHECK_EN poisons transactions whose address is not word aligned.
module tt_external_memory_burst #(
    parameter int    LO_BITS     = 8,
    parameter int    HI_BITS     = 8,
    parameter int    ADDR_BITS   = 16,
    parameter int    WORDS       = 32768,
    parameter int    WAIT_CYCLES = 0,
    parameter int    BURST_LEN   = 1,
    parameter string INIT_HEX    = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LO_BITS-1:0]   bus_lo_out,
    input  logic [HI_BITS-1:0]   bus_hi_out,
    input  logic [HI_BITS-1:0]   bus_hi_oe,
    output logic [LO_BITS-1:0]   lo_in_drive,
    output logic [HI_BITS-1:0]   hi_in_drive,
    output logic                 ready,
    output logic                 err,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);

    localparam int W      = LO_BITS + HI_BITS;
    localparam int B      = W / 8;
    localparam int SHIFT  = $clog2(B);
    localparam int MEM_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_BITS-1:0] STEP      = ADDR_BITS'(B);
    localparam logic [3:0]           LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [3:0]           LAST_WAIT = 4'(WAIT_CYCLES - 1);
`ifdef TTMEM_ALIGN_CHECK_EN
    localparam logic [ADDR_BITS-1:0] LOW_MASK  = ADDR_BITS'(B - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [3:0]             beat_q, beat_d;
    logic [3:0]             wait_q, wait_d;
    logic [15:0]            rd_q, rd_d;
    logic [15:0]            wr_q, wr_d;
    logic                   poison_q, poison_d;

    logic [W-1:0]           mem [WORDS];
    logic [W-1:0]           bus_word;
    logic [W-1:0]           drive_word;
    logic                   oe_all;
    logic                   oe_none;
    logic [31:0]            word_idx;
    logic                   in_range;
    logic [MEM_AW-1:0]      mem_idx;
    logic                   mem_we;

    assign bus_word = {bus_hi_out, bus_lo_out};
    assign oe_all   = &bus_hi_oe;
    assign oe_none  = ~|bus_hi_oe;
    // Low address bits below the word size never reach the array index.
    assign word_idx = 32'(addr_q >> SHIFT);
    assign in_range = word_idx < 32'(WORDS);
    assign mem_idx  = word_idx[MEM_AW-1:0];

    assign {hi_in_drive, lo_in_drive} = drive_word;
    assign rd_count = rd_q;
    assign wr_count = wr_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        poison_d   = poison_q;
        ready      = 1'b0;
        err        = 1'b0;
        mem_we     = 1'b0;
        drive_word = '0;
        case (state_q)
            S_IDLE: begin
                if (oe_all) begin
                    addr_d = bus_word[ADDR_BITS-1:0];
                    beat_d = '0;
                    wait_d = '0;
`ifdef TTMEM_ALIGN_CHECK_EN
                    poison_d = (bus_word[ADDR_BITS-1:0] & LOW_MASK) != '0;
                    err      = poison_d;
`else
                    poison_d = 1'b0;
`endif
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DATA;
                end
            end
            S_WAIT: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == LAST_WAIT) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                ready = 1'b1;
                if (oe_none) begin
                    if (in_range && !poison_q) begin
                        drive_word = mem[mem_idx];
                    end
                    if (!poison_q) begin
                        rd_d = rd_q + 16'd1;
                    end
                    err = !in_range;
                end else if (oe_all) begin
                    mem_we = in_range && !poison_q;
                    if (!poison_q) begin
                        wr_d = wr_q + 16'd1;
                    end
                    err = !in_range;
                end else begin
                    // Mixed output enables: neither a read nor a write.
                    err = 1'b1;
                end
                addr_d = addr_q + STEP;
                if (beat_q == LAST_BEAT) begin
                    state_d = S_IDLE;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            beat_q   <= '0;
            wait_q   <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            poison_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            poison_q <= poison_d;
        end
    end

    // Array contents survive reset; only the transaction state is cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= bus_word;
        end
    end

endmodule
